memory_access_unit: RTL and testbench

MEM-stage initiator for the pipeline's byte-addressed data memory. It accepts one load or store request at a time from the pipeline and drives the memory's synchronous read/write port. It performs zero- or sign-extension of byte loads locally and implements byte stores as read-modify-write, because the memory always writes two bytes. It returns a tagged response and flags out-of-range addresses without touching memory.

---
 rtl/mem_access_pkg.sv | 20 ++
 rtl/load_extender.sv | 19 +
 rtl/memory_access_unit.sv | 123 ++++++++++++
 tb/tb_memory_access_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the MEM-stage data-memory initiator.
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_EXTEND,
        ST_RESP
    } state_t;

    localparam logic [1:0] SIZE_WORD   = 2'b00;
    localparam logic [1:0] SIZE_BYTE_U = 2'b01;
    localparam logic [1:0] SIZE_BYTE_S = 2'b10;
    localparam logic [1:0] SIZE_RSVD   = 2'b11;

    localparam logic [1:0] MEM_NUM_BYTES_WORD = 2'b00;

endpackage

// File: rtl/load_extender.sv
// Zero/sign extension of a 16-bit memory read according to the access size.
module load_extender
    import mem_access_pkg::*;
(
    input  logic [15:0] i_memOut,
    input  logic [1:0]  i_size,
    output logic [15:0] o_data
);

    always_comb begin
        o_data = i_memOut;
        case (i_size)
            SIZE_BYTE_U: o_data = {8'h00, i_memOut[7:0]};
            SIZE_BYTE_S: o_data = {{8{i_memOut[7]}}, i_memOut[7:0]};
            default:     o_data = i_memOut;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// MEM-stage initiator: one load/store at a time, byte stores done as read-modify-write.
module memory_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [1:0]           reqSize,
    input  logic [15:0]          reqAddress,
    input  logic [15:0]          reqData,
    input  logic [TAG_WIDTH-1:0] reqTag,
    output logic                 respValid,
    output logic [15:0]          respData,
    output logic [TAG_WIDTH-1:0] respTag,
    output logic                 respError,
    output logic                 memWrEnable,
    output logic                 memRdEnable,
    output logic [1:0]           memNumberOfByte,
    output logic [15:0]          memAddress,
    output logic [15:0]          memIn,
    input  logic [15:0]          memOut
);

    localparam logic [15:0] LAST_ADDR = 16'(MEM_BYTES - 2);

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic [7:0]  r_data;

    logic        w_accept;
    logic        w_err;
    logic [15:0] w_ext;

    assign w_accept        = reqValid && reqReady;
    assign w_err           = (reqAddress > LAST_ADDR) || (reqSize == SIZE_RSVD);
    assign memNumberOfByte = MEM_NUM_BYTES_WORD;

    load_extender u_load_extender (
        .i_memOut (memOut),
        .i_size   (r_size),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_size      <= SIZE_WORD;
            r_data      <= '0;
            reqReady    <= 1'b0;
            respValid   <= 1'b0;
            respData    <= '0;
            respTag     <= '0;
            respError   <= 1'b0;
            memWrEnable <= 1'b0;
            memRdEnable <= 1'b0;
            memAddress  <= '0;
            memIn       <= '0;
        end else begin
            respValid   <= 1'b0;
            memRdEnable <= 1'b0;
            memWrEnable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    reqReady <= 1'b1;
                    if (w_accept) begin
                        reqReady  <= 1'b0;
                        r_write   <= reqWrite;
                        r_size    <= reqSize;
                        r_data    <= reqData[7:0];
                        respTag   <= reqTag;
                        respData  <= '0;
                        respError <= w_err;
                        if (w_err) begin
                            respValid <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            memAddress <= reqAddress;
                            if (reqWrite && reqSize == SIZE_WORD) begin
                                memIn       <= reqData;
                                memWrEnable <= 1'b1;
                                r_state     <= ST_WRITE;
                            end else begin
                                // loads and byte stores both start with a read
                                memRdEnable <= 1'b1;
                                r_state     <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    r_state <= r_write ? ST_MERGE : ST_EXTEND;
                end
                ST_EXTEND: begin
                    respData  <= w_ext;
                    respValid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_MERGE: begin
                    memIn       <= {memOut[15:8], r_data};
                    memWrEnable <= 1'b1;
                    r_state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    respValid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    reqReady <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit with a behavioural byte memory.
module tb_memory_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic [15:0] reqAddress = '0;
    logic [15:0] reqData = '0;
    logic [2:0]  reqTag = '0;
    logic        respValid;
    logic [15:0] respData;
    logic [2:0]  respTag;
    logic        respError;
    logic        memWrEnable;
    logic        memRdEnable;
    logic [1:0]  memNumberOfByte;
    logic [15:0] memAddress;
    logic [15:0] memIn;
    logic [15:0] memOut = '0;

    memory_access_unit #(.MEM_BYTES(256), .TAG_WIDTH(3)) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqAddress(reqAddress), .reqData(reqData), .reqTag(reqTag),
        .respValid(respValid), .respData(respData), .respTag(respTag), .respError(respError),
        .memWrEnable(memWrEnable), .memRdEnable(memRdEnable),
        .memNumberOfByte(memNumberOfByte), .memAddress(memAddress),
        .memIn(memIn), .memOut(memOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  tag;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_resp_edge = -100;
    int n_accepts = 0;
    int n_resp = 0;
    int n_wr = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit b2b_mode = 1'b0;
    int b2b_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural synchronous memory: read data valid the cycle after the strobe
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[1] = 8'h01; ref_mem[1] = 8'h01;
        mem[2] = 8'h02; ref_mem[2] = 8'h02;
        forever begin
            @(posedge clk);
            if (memRdEnable) memOut <= {mem[memAddress[7:0] + 8'd1], mem[memAddress[7:0]]};
            if (memWrEnable) begin
                mem[memAddress[7:0]]        <= memIn[7:0];
                mem[memAddress[7:0] + 8'd1] <= memIn[15:8];
            end
        end
    end

    // accept tracker on the active edge (reads pre-update values)
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (resetN && reqValid && reqReady) begin
                if (b2b_mode && b2b_seen > 0) chk("b2b_accept_edge", cyc, last_resp_edge + 1);
                if (b2b_mode) b2b_seen++;
                accept_cyc = cyc;
                n_accepts++;
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // response monitor and strobe invariants, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("strobe_exclusive", {31'd0, memWrEnable && memRdEnable}, 32'd0);
            chk("num_bytes", {30'd0, memNumberOfByte}, 32'd0);
            if (memRdEnable) rd_cnt++;
            if (memWrEnable) begin wr_cnt++; n_wr++; end
            if (respValid) begin
                n_resp++;
                last_resp_edge = cyc + 1;
                if (q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_data", {16'd0, respData}, {16'd0, e.data});
                    chk("resp_tag", {29'd0, respTag}, {29'd0, e.tag});
                    chk("resp_err", {31'd0, respError}, {31'd0, e.err});
                    chk("resp_latency", cyc + 1 - accept_cyc, e.lat);
                    chk("rd_strobes", rd_cnt, e.rd);
                    chk("wr_strobes", wr_cnt, e.wr);
                end
            end
        end
    end

    function automatic logic [15:0] model_load(input logic [1:0] sz, input logic [15:0] a);
        logic [7:0] lo, hi;
        lo = ref_mem[a[7:0]];
        hi = ref_mem[a[7:0] + 8'd1];
        case (sz)
            2'b00:   return {hi, lo};
            2'b01:   return {8'h00, lo};
            default: return {{8{lo[7]}}, lo};
        endcase
    endfunction

    // called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input bit w, input logic [1:0] sz, input logic [15:0] addr,
                         input logic [15:0] data, input logic [2:0] tag,
                         input logic [15:0] exp_d, input bit hold, input bit push);
        exp_t e;
        int   t;
        bit   err;
        err    = (addr > 16'd254) || (sz == 2'b11);
        e.data = (err || w) ? 16'h0000 : exp_d;
        e.tag  = tag;
        e.err  = err;
        if (err)                    begin e.lat = 1; e.rd = 0; e.wr = 0; end
        else if (!w)                begin e.lat = 3; e.rd = 1; e.wr = 0; end
        else if (sz == 2'b00)       begin e.lat = 2; e.rd = 0; e.wr = 1; end
        else                        begin e.lat = 4; e.rd = 1; e.wr = 1; end
        if (push) begin
            q.push_back(e);
            if (!err && w) begin
                ref_mem[addr[7:0]] = data[7:0];
                if (sz == 2'b00) ref_mem[addr[7:0] + 8'd1] = data[15:8];
            end
        end
        reqWrite   = w;
        reqSize    = sz;
        reqAddress = addr;
        reqData    = data;
        reqTag     = tag;
        reqValid   = 1'b1;
        t = 0;
        while (!reqReady && t < 100) begin @(negedge clk); t++; end
        if (!reqReady) begin
            chk("accept_timeout", 32'd0, 32'd1);
            reqValid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) reqValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, wr0, resp0;
        logic [1:0]  sz;
        logic [15:0] a, d;
        bit          w;

        repeat (3) @(negedge clk);
        chk("rst_reqReady", {31'd0, reqReady}, 32'd0);
        chk("rst_respValid", {31'd0, respValid}, 32'd0);
        chk("rst_respError", {31'd0, respError}, 32'd0);
        chk("rst_memWr", {31'd0, memWrEnable}, 32'd0);
        chk("rst_memRd", {31'd0, memRdEnable}, 32'd0);
        chk("rst_respData", {16'd0, respData}, 32'd0);
        chk("rst_memAddress", {16'd0, memAddress}, 32'd0);
        chk("rst_memIn", {16'd0, memIn}, 32'd0);
        chk("rst_respTag", {29'd0, respTag}, 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, reqReady}, 32'd1);

        issue(1'b0, 2'b00, 16'd1, 16'h0000, 3'd5, 16'h0201, 1'b0, 1'b1);
        drain();
        issue(1'b1, 2'b00, 16'd10, 16'hBEEF, 3'd1, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(1'b1, 2'b01, 16'd10, 16'h1280, 3'd2, 16'h0000, 1'b0, 1'b1);
        drain();
        chk("mem10_after_byte_store", {24'd0, mem[10]}, 32'h80);
        chk("mem11_after_byte_store", {24'd0, mem[11]}, 32'hBE);
        issue(1'b0, 2'b10, 16'd10, 16'h0000, 3'd3, 16'hFF80, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b01, 16'd10, 16'h0000, 3'd4, 16'h0080, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b00, 16'd10, 16'h0000, 3'd6, 16'hBE80, 1'b0, 1'b1);
        drain();

        issue(1'b0, 2'b00, 16'd254, 16'h0000, 3'd0, 16'hA5A4, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b00, 16'd255, 16'h0000, 3'd1, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(1'b1, 2'b00, 16'hFFFF, 16'h1234, 3'd7, 16'h0000, 1'b0, 1'b1);
        drain();
        issue(1'b0, 2'b11, 16'd20, 16'h0000, 3'd2, 16'h0000, 1'b0, 1'b1);
        drain();

        acc0     = n_accepts;
        b2b_seen = 0;
        b2b_mode = 1'b1;
        issue(1'b0, 2'b00, 16'd10, 16'h0000, 3'd3, 16'hBE80, 1'b1, 1'b1);
        issue(1'b1, 2'b01, 16'd12, 16'hAA11, 3'd4, 16'h0000, 1'b1, 1'b1);
        issue(1'b0, 2'b00, 16'd12, 16'h0000, 3'd6, 16'h5711, 1'b0, 1'b1);
        drain();
        b2b_mode = 1'b0;
        chk("busy_accept_count", n_accepts - acc0, 32'd3);

        wr0   = n_wr;
        resp0 = n_resp;
        issue(1'b1, 2'b01, 16'd12, 16'h0033, 3'd5, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("rst_mid_wr", {31'd0, memWrEnable}, 32'd0);
        chk("rst_mid_rd", {31'd0, memRdEnable}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid_ready_low", {31'd0, reqReady}, 32'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_release", {31'd0, reqReady}, 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_mid_mem12", {24'd0, mem[12]}, 32'h11);
        chk("rst_mid_mem13", {24'd0, mem[13]}, 32'h57);
        chk("rst_mid_no_write", n_wr - wr0, 32'd0);
        chk("rst_mid_no_resp", n_resp - resp0, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(255, 65535))
                                              : 16'($urandom_range(0, 31));
            d  = 16'($urandom);
            issue(w, sz, a, d, 3'(i), model_load(sz, a), (i != 999), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
